// File: rtl/score_seg_scanner.sv
// score_seg_scanner: packed-BCD score to multiplexed common-cathode 7-segment display.
// A new score is captured on score_valid and committed only at a scan-frame boundary,
// so a frame never shows a mix of old and new digits. Leading zeros are blanked, and
// nibbles above 9 are shown as a dash and set a sticky bcd_err flag.
// Optional feature macro: SCORE_BLINK_EN (flash the display for BLINK_FRAMES frames after a commit).
module score_seg_scanner #(
    parameter int unsigned DIGITS       = 3,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [4*DIGITS-1:0]   Score,
    input  logic                  score_valid,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  upd_ack,
    output logic                  bcd_err
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    // Reject configurations the scan timing cannot support.
    if (SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_cfg_check
        $error("score_seg_scanner: SCAN_DIV must be >= 2 and BLINK_FRAMES >= 1");
    end

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [SW-1:0] staging;
    logic [SW-1:0] display;
    logic          pending;

    logic          tc_c;
    logic          boundary_c;
    logic          commit_c;
    logic [3:0]    nib_c;
    logic          upper_nz_c;
    logic          blank_c;
    logic          dark_c;

    assign tc_c       = (cnt == CNT_LAST);
    assign boundary_c = tc_c && (idx == IDX_LAST);
    assign commit_c   = boundary_c && (score_valid || pending);

    // Nibble to gfedcba segments; anything above 9 becomes a dash.
    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h40;
        endcase
    endfunction

    // Slot divider and digit index.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt <= '0;
            idx <= '0;
        end else if (tc_c) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Capture into staging; commit to display only at a frame boundary.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            staging <= '0;
            display <= '0;
            pending <= 1'b0;
        end else if (boundary_c && score_valid) begin
            staging <= Score;
            display <= Score;
            pending <= 1'b0;
        end else if (boundary_c && pending) begin
            display <= staging;
            pending <= 1'b0;
        end else if (score_valid) begin
            staging <= Score;
            pending <= 1'b1;
        end
    end

    // Select the current nibble and detect whether it and all higher nibbles are zero.
    always_comb begin
        nib_c      = 4'd0;
        upper_nz_c = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx) begin
                nib_c = display[4*k +: 4];
            end
            if (IW'(k) >= idx && display[4*k +: 4] != 4'd0) begin
                upper_nz_c = 1'b1;
            end
        end
    end

    assign blank_c = (idx != '0) && !upper_nz_c;

`ifdef SCORE_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_cnt;
    logic          odd_frame;

    // Blink countdown per frame after each commit; odd frames go dark.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt <= '0;
            odd_frame <= 1'b0;
        end else if (commit_c) begin
            blink_cnt <= BW'(BLINK_FRAMES);
            odd_frame <= 1'b0;
        end else if (boundary_c) begin
            odd_frame <= ~odd_frame;
            if (blink_cnt != '0) begin
                blink_cnt <= blink_cnt - BW'(1);
            end
        end
    end

    assign dark_c = (blink_cnt != '0) && odd_frame;
`else
    assign dark_c = 1'b0;
`endif

    // Registered pin stage, commit acknowledge and sticky invalid-BCD flag.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            seg      <= '0;
            digit_en <= '0;
            upd_ack  <= 1'b0;
            bcd_err  <= 1'b0;
        end else begin
            upd_ack <= commit_c;
            if (blank_c || dark_c) begin
                seg      <= '0;
                digit_en <= '0;
            end else begin
                seg      <= enc(nib_c);
                digit_en <= DIGITS'(1) << idx;
            end
            if (!blank_c && nib_c > 4'd9) begin
                bcd_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_score_seg_scanner.sv
// Bench for score_seg_scanner (DIGITS=3, SCAN_DIV=4): cycle-indexed reference model,
// per-frame expectation table, hand-written corner sequences and random strobes.
module tb_score_seg_scanner;

    localparam int SD = 4;
    localparam int DG = 3;
    localparam int FR = SD * DG;

    logic        clk;
    logic        resetN;
    logic [11:0] Score;
    logic        score_valid;
    logic [6:0]  seg;
    logic [2:0]  digit_en;
    logic        upd_ack;
    logic        bcd_err;

    score_seg_scanner #(.DIGITS(DG), .SCAN_DIV(SD), .BLINK_FRAMES(8)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .Score       (Score),
        .score_valid (score_valid),
        .seg         (seg),
        .digit_en    (digit_en),
        .upd_ack     (upd_ack),
        .bcd_err     (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n      = 0;
    int ack_cnt = 0;

    logic [6:0]  seg_tab [10];
    logic [11:0] m_disp;
    logic [11:0] m_stage;
    logic        m_pend;
    logic        m_err;

    typedef struct packed {
        logic [11:0]     score;
        logic [2:0][6:0] sg;   // [2]=hundreds .. [0]=units
        logic [2:0][2:0] en;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, n);
        end
    endtask

    // One clock: compute what the pins must show after this edge, apply inputs, compare.
    task automatic step(input logic v, input logic [11:0] s);
        int         ib;
        logic [11:0] d;
        logic [3:0] nib;
        logic [6:0] es;
        logic [2:0] ee;
        logic       ack;
        ib  = (n / SD) % DG;
        d   = m_disp;
        nib = 4'(d >> (4 * ib));
        if (ib != 0 && 12'(d >> (4 * ib)) == 12'd0) begin
            es = 7'h00;
            ee = 3'b000;
        end else begin
            ee = 3'(1 << ib);
            if (nib > 4'd9) begin
                es    = 7'h40;
                m_err = 1'b1;
            end else begin
                es = seg_tab[nib];
            end
        end
        ack = 1'b0;
        if ((n % FR) == FR - 1 && (v || m_pend)) begin
            m_disp = v ? s : m_stage;
            m_pend = 1'b0;
            ack    = 1'b1;
        end else if (v) begin
            m_stage = s;
            m_pend  = 1'b1;
        end
        Score       = s;
        score_valid = v;
        @(posedge clk);
        #1;
        chk("seg", 32'(seg), 32'(es));
        chk("digit_en", 32'(digit_en), 32'(ee));
        chk("upd_ack", 32'(upd_ack), 32'(ack));
        chk("bcd_err", 32'(bcd_err), 32'(m_err));
        if (upd_ack) ack_cnt++;
        n++;
    endtask

    task automatic run_to(input int ph);
        while ((n % FR) != ph) step(1'b0, 12'h000);
    endtask

    task automatic run(input int cyc);
        for (int i = 0; i < cyc; i++) step(1'b0, 12'h000);
    endtask

    task automatic model_reset();
        n       = 0;
        m_disp  = '0;
        m_stage = '0;
        m_pend  = 1'b0;
        m_err   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] sc;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        tbl[0] = '{12'h207, {7'h5B, 7'h3F, 7'h07}, {3'b100, 3'b010, 3'b001}};
        tbl[1] = '{12'h099, {7'h00, 7'h6F, 7'h6F}, {3'b000, 3'b010, 3'b001}};
        tbl[2] = '{12'h300, {7'h4F, 7'h3F, 7'h3F}, {3'b100, 3'b010, 3'b001}};
        tbl[3] = '{12'h090, {7'h00, 7'h6F, 7'h3F}, {3'b000, 3'b010, 3'b001}};
        tbl[4] = '{12'h999, {7'h6F, 7'h6F, 7'h6F}, {3'b100, 3'b010, 3'b001}};
        tbl[5] = '{12'h000, {7'h00, 7'h00, 7'h3F}, {3'b000, 3'b000, 3'b001}};
        tbl[6] = '{12'h0A5, {7'h00, 7'h40, 7'h6D}, {3'b000, 3'b010, 3'b001}};
        tbl[7] = '{12'h005, {7'h00, 7'h00, 7'h6D}, {3'b000, 3'b000, 3'b001}};

        resetN      = 1'b0;
        Score       = '0;
        score_valid = 1'b0;
        model_reset();
        #23;
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_digit_en", 32'(digit_en), 32'h0);
        chk("rst_upd_ack", 32'(upd_ack), 32'h0);
        chk("rst_bcd_err", 32'(bcd_err), 32'h0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // Idle frames after reset: units "0", upper slots blanked.
        run(2 * FR);

        // Table: strobe mid-frame, then check each slot of the following frame.
        for (int i = 0; i < 8; i++) begin
            ack_cnt = 0;
            run_to(5);
            step(1'b1, tbl[i].score);
            run_to(0);
            for (int s = 0; s < DG; s++) begin
                for (int j = 0; j < SD; j++) begin
                    step(1'b0, 12'h000);
                    if (j == 1) begin
                        chk("tbl_seg", 32'(seg), 32'(tbl[i].sg[s]));
                        chk("tbl_en", 32'(digit_en), 32'(tbl[i].en[s]));
                    end
                end
            end
            chk("tbl_ack_count", 32'(ack_cnt), 32'd1);
        end
        chk("bcd_err_sticky", 32'(bcd_err), 32'd1);

        // Two strobes in one frame: only the latest commits, one acknowledge.
        ack_cnt = 0;
        run_to(2);
        step(1'b1, 12'h015);
        step(1'b0, 12'h000);
        step(1'b1, 12'h099);
        run_to(0);
        run(FR);
        chk("double_strobe_ack", 32'(ack_cnt), 32'd1);

        // Strobe exactly on the boundary cycle: goes straight to display, no later ack.
        ack_cnt = 0;
        run_to(FR - 1);
        step(1'b1, 12'h300);
        run(2 * FR);
        chk("boundary_strobe_ack", 32'(ack_cnt), 32'd1);

        // Random strobes with occasional invalid nibbles and leading zeros.
        for (int i = 0; i < 600; i++) begin
            sc = '0;
            for (int k = 0; k < DG; k++) begin
                if ($urandom_range(0, 7) == 0) sc[4*k +: 4] = 4'($urandom_range(10, 15));
                else                           sc[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 2) == 0) sc[11:8] = 4'h0;
            if ($urandom_range(0, 3) == 0) sc[7:4]  = 4'h0;
            step($urandom_range(0, 5) == 0, sc);
        end

        // Reset mid-slot with a capture pending: async clear, capture is discarded.
        run_to(5);
        step(1'b1, 12'h123);
        step(1'b0, 12'h000);
        resetN = 1'b0;
        #2;
        chk("async_rst_seg", 32'(seg), 32'h0);
        chk("async_rst_digit_en", 32'(digit_en), 32'h0);
        chk("async_rst_upd_ack", 32'(upd_ack), 32'h0);
        chk("async_rst_bcd_err", 32'(bcd_err), 32'h0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
        ack_cnt = 0;
        run(3 * FR);
        chk("stale_capture_ack", 32'(ack_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
